led_flash_multi: RTL and testbench
==================================

Name: led_flash_multi

Overview:
Multi-channel successor to the single-LED stepped-period flasher. One shared period counter sweeps through STEPS periods, growing linearly from BASE_PERIOD by STEP each time. Each period drives a registered on-phase onto CH LED outputs under one of four display modes. It sits directly on board LED pins and replaces the per-LED flashers.

Parameters:
CH, 4, number of LED channels (>=2)
CNT_W, 29, width of the period counter
ON_TIME, 50_000_000, cycles from period start before the LED turns on (>=1, < BASE_PERIOD)
BASE_PERIOD, 100_000_000, length of step 0 in clk cycles
STEP, 50_000_000, added period length per step
STEPS, 9, number of steps per sweep (>=1); step index is $clog2(STEPS) wide, minimum 1
ACTIVE_LOW, 1, 1 = LED lit at 0, 0 = LED lit at 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = run; 0 = freeze counters, all LEDs unlit
mode  input  2  0 sync, 1 chase, 2 alternate, 3 blank
led  output  CH  LED drive, polarity per ACTIVE_LOW
step_idx  output  $clog2(STEPS)  current step, 0..STEPS-1
sweep_done  output  1  one-cycle pulse after the last period of a sweep ends

Behaviour:
- Reset is asynchronous, active-low, on clk. All state is cleared: cnt=0, step_idx=0, ch_idx=0, on_flag=0, mode_q=0, en_q=0, sweep_done=0. The led bus is all unlit (all 1s when ACTIVE_LOW=1).
- period = BASE_PERIOD + STEP*step_idx, computed in CNT_W bits. The maximum period, BASE_PERIOD + STEP*(STEPS-1), must be < 2^CNT_W; elaboration fails otherwise.
- add_cnt = en; end_cnt = add_cnt && cnt==period-1.
- cnt: on add_cnt it increments, and wraps to 0 on end_cnt. With en=0 it holds.
- step_idx: increments on end_cnt and wraps from STEPS-1 to 0. With STEPS=1 it stays 0.
- on_flag:
  - set at the edge where add_cnt && cnt==ON_TIME-1;
  - cleared at the edge of end_cnt;
  - otherwise held.
  - Net effect: on_flag==1 exactly when cnt>=ON_TIME, giving period-ON_TIME lit cycles per period.
- sweep_done: registered. It is 1 for exactly one cycle after the edge where end_cnt && step_idx==STEPS-1, and 0 otherwise.
- en_q: en registered each edge.
- mode_q: loads mode at any edge where end_cnt or en_q==0. A mode change while running therefore takes effect at the next period boundary. While disabled it takes effect one cycle later.
- ch_idx: advances on end_cnt only when mode_q==1, wrapping CH-1 to 0. It holds in other modes. It is not reset on a mode change.
- led is a pure decode of registered state, with no input-to-output combinational path. "lit" below means the active level.
  - en_q==0: all unlit.
  - mode_q 0 (sync): every channel lit iff on_flag.
  - mode_q 1 (chase): channel ch_idx lit iff on_flag; all other channels unlit.
  - mode_q 2 (alternate): even-index channels lit iff on_flag; odd-index channels lit iff !on_flag.
  - mode_q 3 (blank): all unlit. Counters keep running.
- Simultaneous events:
  - end_cnt takes priority over the on_flag set. This cannot coincide because ON_TIME < BASE_PERIOD.
  - end_cnt with a mode change: the new mode_q and the advanced ch_idx/step_idx apply together on the next cycle.
- en dropping mid-period: cnt, step_idx, ch_idx and on_flag freeze. On re-enable, the period resumes from the frozen cnt. There is no restart.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Test Plan:
Shared parameters for all scenarios: CH=4, ON_TIME=2, BASE_PERIOD=4, STEP=2, STEPS=3, ACTIVE_LOW=1.
1. Reset, en=1, mode=0, run 18 cycles -> led=4'b0000 for 2 of period 4, 4 of period 6, and 6 of period 8, else 4'b1111. step_idx runs 0,1,2,0. sweep_done is high exactly at cycle 18.
2. mode=1 from reset -> the single lit channel moves 0,1,2,3,0 across consecutive periods, for example led=4'b1110 then 4'b1101. All LEDs are unlit in the first ON_TIME cycles of each period.
3. mode=2 -> during the off phase led=4'b0101 (odd channels lit); during the on phase led=4'b1010.
4. Change mode 0->3 mid-period -> led keeps the sync pattern until end_cnt, then shows 4'b1111 while step_idx keeps advancing.
5. Drop en for 5 cycles at cnt=3 of period 6 -> led=4'b1111 one cycle later and cnt/step_idx held. Re-raise en -> the remaining 2 lit cycles complete, then step_idx advances.
6. Assert rst_n=0 mid-sweep between clock edges -> led=4'b1111, step_idx=0 and sweep_done=0 immediately. After release, scenario 1 timing repeats exactly.

Source files
------------

// File: rtl/led_flash_multi.sv
// Multi-channel stepped-period LED flasher: one shared period counter sweeps STEPS
// linearly growing periods and its on-phase is decoded onto CH LEDs per display mode.
module led_flash_multi #(
    parameter int CH          = 4,
    parameter int CNT_W       = 29,
    parameter int ON_TIME     = 50_000_000,
    parameter int BASE_PERIOD = 100_000_000,
    parameter int STEP        = 50_000_000,
    parameter int STEPS       = 9,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        en,
    input  logic [1:0]                                  mode,
    output logic [CH-1:0]                               led,
    output logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0] step_idx,
    output logic                                        sweep_done
);

    localparam int SW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CHW = $clog2(CH);
    localparam longint MAX_PERIOD = longint'(BASE_PERIOD) + longint'(STEP) * longint'(STEPS - 1);

    // The longest period must still be representable in the counter.
    if (MAX_PERIOD >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("led_flash_multi: maximum period does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    step_q, step_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic             on_q, on_d;
    logic [1:0]       mode_q, mode_d;
    logic             en_q, en_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] period;
    logic             add_cnt;
    logic             end_cnt;
    logic [CH-1:0]    lit;

    assign period  = CNT_W'(BASE_PERIOD) + CNT_W'(STEP) * CNT_W'(step_q);
    assign add_cnt = en;
    assign end_cnt = add_cnt && (cnt_q == period - CNT_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        ch_d   = ch_q;
        on_d   = on_q;
        mode_d = mode_q;
        en_d   = en;
        done_d = end_cnt && (step_q == SW'(STEPS - 1));

        if (add_cnt) begin
            cnt_d = end_cnt ? '0 : cnt_q + CNT_W'(1);
        end
        if (end_cnt) begin
            step_d = (step_q == SW'(STEPS - 1)) ? '0 : step_q + SW'(1);
            if (mode_q == 2'd1) begin
                ch_d = (ch_q == CHW'(CH - 1)) ? '0 : ch_q + CHW'(1);
            end
        end
        // End of period wins over the on-phase start (they cannot coincide anyway).
        if (end_cnt) begin
            on_d = 1'b0;
        end else if (add_cnt && (cnt_q == CNT_W'(ON_TIME - 1))) begin
            on_d = 1'b1;
        end
        // Mode changes land on a period boundary, or promptly while disabled.
        if (end_cnt || !en_q) begin
            mode_d = mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            step_q <= '0;
            ch_q   <= '0;
            on_q   <= 1'b0;
            mode_q <= 2'd0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            ch_q   <= ch_d;
            on_q   <= on_d;
            mode_q <= mode_d;
            en_q   <= en_d;
            done_q <= done_d;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        assign lit[gi] = en_q && (
               ((mode_q == 2'd0) && on_q)
            || ((mode_q == 2'd1) && on_q && (ch_q == CHW'(gi)))
            || ((mode_q == 2'd2) && (((gi % 2) == 0) ? on_q : !on_q)));
    end

    assign led        = (ACTIVE_LOW != 0) ? ~lit : lit;
    assign step_idx   = step_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_led_flash_multi.sv
// Bench for led_flash_multi: directed scenarios plus random en/mode traffic, each
// cycle compared against a model that derives the period position from elapsed run time.
module tb_led_flash_multi;

    localparam int CH          = 4;
    localparam int CNT_W       = 8;
    localparam int ON_TIME     = 2;
    localparam int BASE_PERIOD = 4;
    localparam int STEP        = 2;
    localparam int STEPS       = 3;
    localparam int ACTIVE_LOW  = 1;
    localparam int SWEEP       = STEPS * BASE_PERIOD + STEP * STEPS * (STEPS - 1) / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  led;
    logic [1:0]  step_idx;
    logic        sweep_done;

    int tests = 0;
    int fails = 0;

    // Model state: enabled cycles since reset plus the slow-changing registered bits.
    int         t_m;
    bit         enq_m;
    bit         done_m;
    logic [1:0] mode_m;
    int         ch_m;

    led_flash_multi #(
        .CH(CH), .CNT_W(CNT_W), .ON_TIME(ON_TIME), .BASE_PERIOD(BASE_PERIOD),
        .STEP(STEP), .STEPS(STEPS), .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .led(led), .step_idx(step_idx), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    function automatic int per(input int s);
        return BASE_PERIOD + STEP * s;
    endfunction

    function automatic void pos(output int s, output int c);
        int tt;
        tt = t_m % SWEEP;
        s  = 0;
        while (tt >= per(s)) begin
            tt -= per(s);
            s++;
        end
        c = tt;
    endfunction

    function automatic logic [3:0] exp_led();
        int s, c;
        bit on;
        logic [3:0] lit;
        pos(s, c);
        on  = (c >= ON_TIME);
        lit = 4'b0000;
        if (enq_m) begin
            case (mode_m)
                2'd0: lit = on ? 4'b1111 : 4'b0000;
                2'd1: lit[ch_m] = on;
                2'd2: lit = on ? 4'b0101 : 4'b1010;
                default: lit = 4'b0000;
            endcase
        end
        return (ACTIVE_LOW != 0) ? ~lit : lit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        int s, c;
        pos(s, c);
        check("led", 32'(led), 32'(exp_led()));
        check("step_idx", 32'(step_idx), 32'(s));
        check("sweep_done", 32'(sweep_done), 32'(done_m));
    endtask

    task automatic model_reset();
        t_m    = 0;
        enq_m  = 1'b0;
        done_m = 1'b0;
        mode_m = 2'd0;
        ch_m   = 0;
    endtask

    // Drive inputs for the coming edge, advance the model over it, then compare.
    task automatic tick(input bit e, input logic [1:0] m);
        int s, c;
        bit endc;
        en   = e;
        mode = m;
        pos(s, c);
        endc   = e && (c == per(s) - 1);
        if (e) t_m++;
        done_m = endc && (s == STEPS - 1);
        if (endc && mode_m == 2'd1) ch_m = (ch_m + 1) % CH;
        if (endc || !enq_m) mode_m = m;
        enq_m  = e;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'h0000_000f);
        check("rst_step", 32'(step_idx), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int s, c, k;
        logic [1:0] rmode;

        model_reset();
        #12;
        check("por_led", 32'(led), 32'h0000_000f);
        check("por_step", 32'(step_idx), 32'd0);
        check("por_done", 32'(sweep_done), 32'd0);
        rst_n = 1'b1;
        $display("[TB] scenario 1: sync sweep");
        repeat (SWEEP + 2) tick(1'b1, 2'd0);

        $display("[TB] scenario 2: chase");
        apply_reset();
        repeat (30) tick(1'b1, 2'd1);

        $display("[TB] scenario 3: alternate");
        apply_reset();
        repeat (20) tick(1'b1, 2'd2);

        $display("[TB] scenario 4: sync to blank mid-period");
        apply_reset();
        repeat (7) tick(1'b1, 2'd0);
        repeat (20) tick(1'b1, 2'd3);

        $display("[TB] scenario 5: enable drop at cnt=3 of period 6");
        apply_reset();
        k = 0;
        pos(s, c);
        while (!(s == 1 && c == 3) && k < 40) begin
            tick(1'b1, 2'd0);
            k++;
            pos(s, c);
        end
        repeat (5) tick(1'b0, 2'd0);
        repeat (12) tick(1'b1, 2'd0);

        $display("[TB] random en/mode traffic");
        apply_reset();
        rmode = 2'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rmode = 2'($urandom_range(0, 3));
            tick(1'($urandom_range(0, 9) != 0), rmode);
        end

        $display("[TB] scenario 6: reset mid-sweep, sync timing repeats");
        apply_reset();
        repeat (SWEEP + 2) tick(1'b1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
